// File: rtl/spi_master_shifter.sv
// spi_master_shifter
// SPI master word engine (CPHA = 0) sitting between a TX FIFO and an RX FIFO.
// Pops one word from the TX FIFO, shifts it out MSB first on o_mosi while
// shifting i_miso in, then pushes the received word into the RX FIFO.
//
// Parameters
//   DWIDTH  : bits per SPI word (>= 2) and FIFO data width
//   CLK_DIV : i_clk cycles per SCLK half-period (>= 1)
//   CPOL    : SCLK idle level
//
// Ports
//   i_clk, i_rst        : system clock (rising edge), async active-high reset
//   i_en                : permits starting new words
//   tx_empty/tx_ren     : TX FIFO empty flag / pop request
//   tx_data             : TX FIFO read data, valid the cycle after a pop
//   rx_full/rx_wen      : RX FIFO full flag / push strobe
//   rx_data             : received word
//   o_sclk/o_mosi/i_miso/o_cs_n : SPI bus
//   o_busy              : FSM not idle
//   o_overrun           : sticky, set when a received word is dropped
module spi_master_shifter #(
  parameter int DWIDTH  = 8,
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              tx_empty,
  output logic              tx_ren,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              rx_full,
  output logic              rx_wen,
  output logic [DWIDTH-1:0] rx_data,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(DWIDTH) + 1;
  localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DWIDTH - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(2 * CLK_DIV - 1);

  state_t              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [DWIDTH-1:0]   shreg_q;
  logic                tx_ren_q;
  logic                rx_wen_q;
  logic [DWIDTH-1:0]   rx_data_q;
  logic                sclk_q;
  logic                mosi_q;
  logic                cs_n_q;
  logic                busy_q;
  logic                overrun_q;
  logic                start_s;

  // A new word may start only when enabled and the TX FIFO has data.
  assign start_s = i_en & ~tx_empty;

  // Word sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      shreg_q   <= '0;
      tx_ren_q  <= 1'b0;
      rx_wen_q  <= 1'b0;
      rx_data_q <= '0;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      tx_ren_q <= 1'b0;
      rx_wen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cs_n_q <= 1'b1;
          sclk_q <= CPOL;
          mosi_q <= 1'b0;
          if (start_s) begin
            state_q  <= FETCH;
            tx_ren_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        FETCH: begin
          // tx_data becomes valid during LOAD; select the slave now.
          state_q <= LOAD;
          cs_n_q  <= 1'b0;
        end
        LOAD: begin
          shreg_q   <= tx_data;
          mosi_q    <= tx_data[DWIDTH-1];
          div_cnt_q <= '0;
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt_q == HALF_LAST) begin
            // Leading edge: sample MISO. The MSB leaving the register has
            // already been on MOSI for the whole first half-period.
            sclk_q    <= ~CPOL;
            shreg_q   <= {shreg_q[DWIDTH-2:0], i_miso};
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end else if (div_cnt_q == FULL_LAST) begin
            // Trailing edge: launch the next bit or finish the word.
            sclk_q    <= CPOL;
            div_cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_q   <= DONE;
              rx_data_q <= shreg_q;
              mosi_q    <= 1'b0;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              mosi_q    <= shreg_q[DWIDTH-1];
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        DONE: begin
          if (rx_full) begin
            overrun_q <= 1'b1;
          end else begin
            rx_wen_q <= 1'b1;
          end
          if (start_s) begin
            // Back-to-back: chip select stays asserted.
            state_q  <= FETCH;
            tx_ren_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= CPOL;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ren    = tx_ren_q;
  assign rx_wen    = rx_wen_q;
  assign rx_data   = rx_data_q;
  assign o_sclk    = sclk_q;
  assign o_mosi    = mosi_q;
  assign o_cs_n    = cs_n_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

endmodule

// File: doc/spi_master_shifter.md
SPI_MASTER_SHIFTER -- requirements
Module: spi_master_shifter

Interface
REQ-001 The block SHALL have the parameter DWIDTH, default 8, giving bits per SPI word and the FIFO data width.
REQ-002 The block SHALL have the parameter CLK_DIV, default 2, giving i_clk cycles per SCLK half-period (legal values >= 1).
REQ-003 The block SHALL have the parameter CPOL, default 0, giving the SCLK idle level; data is launched on the trailing edge and sampled on the leading edge (CPHA=0 only).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high; ports i_clk and i_rst.
REQ-005 The block SHALL have the port i_clk, input, 1 bit: the system clock; all logic uses its rising edge.
REQ-006 The block SHALL have the port i_rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have the port i_en, input, 1 bit: permits starting new words.
REQ-008 The block SHALL have the port tx_empty, input, 1 bit: TX FIFO empty flag.
REQ-009 The block SHALL have the port tx_ren, output, 1 bit: TX FIFO pop request.
REQ-010 The block SHALL have the port tx_data, input, DWIDTH bits: TX FIFO read data, valid on the cycle after a pop.
REQ-011 The block SHALL have the port rx_full, input, 1 bit: RX FIFO full flag.
REQ-012 The block SHALL have the port rx_wen, output, 1 bit: RX FIFO push strobe.
REQ-013 The block SHALL have the port rx_data, output, DWIDTH bits: received word.
REQ-014 The block SHALL have the port o_sclk, output, 1 bit: SPI clock.
REQ-015 The block SHALL have the port o_mosi, output, 1 bit: serial data out, MSB first.
REQ-016 The block SHALL have the port i_miso, input, 1 bit: serial data in, MSB first.
REQ-017 The block SHALL have the port o_cs_n, output, 1 bit: active-low chip select.
REQ-018 The block SHALL have the ports o_busy and o_overrun, each output, 1 bit: o_busy = FSM not IDLE; o_overrun = sticky flag for a dropped RX word.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, FETCH, LOAD, SHIFT and DONE.
REQ-020 In IDLE, if i_en=1 and tx_empty=0, the next state SHALL be FETCH; otherwise the FSM SHALL remain in IDLE with o_cs_n=1, o_sclk=CPOL and o_mosi=0.
REQ-021 tx_ren SHALL be 1 for exactly the single FETCH cycle and 0 in every other state.
REQ-022 In LOAD, the shift register SHALL capture tx_data, o_cs_n SHALL go to 0 and o_mosi SHALL present bit DWIDTH-1, registered, from the next cycle; the next state SHALL be SHIFT.
REQ-023 In SHIFT, each bit SHALL take 2*CLK_DIV cycles: o_sclk SHALL toggle to the leading edge after CLK_DIV cycles, sampling i_miso into the LSB side, and SHALL toggle back after a further CLK_DIV cycles, at which point the next MOSI bit shifts out.
REQ-024 The bit counter SHALL be $clog2(DWIDTH)+1 bits wide; after the DWIDTH-th trailing edge the next state SHALL be DONE, with o_sclk=CPOL.
REQ-025 In DONE, rx_data SHALL hold the sampled word; if rx_full=0, rx_wen SHALL pulse for exactly 1 cycle; if rx_full=1, rx_wen SHALL stay 0 and o_overrun SHALL be set.
REQ-026 From DONE, if i_en=1 and tx_empty=0, the next state SHALL be FETCH with o_cs_n held at 0 (back-to-back); otherwise the next state SHALL be IDLE with o_cs_n returning to 1.
REQ-027 Word latency from leaving IDLE to the DONE cycle SHALL be 2 + 2*CLK_DIV*DWIDTH cycles; for the defaults this is 34 cycles, with DONE on the 35th.
REQ-028 Deasserting i_en in the middle of a word SHALL NOT abort it; the word SHALL complete and the FSM SHALL then go to IDLE.
REQ-029 A change in tx_empty or rx_full outside FETCH-entry or DONE SHALL have no effect.
REQ-030 o_overrun SHALL clear only on reset.

Reset
REQ-031 i_rst=1 SHALL asynchronously force: state IDLE, o_cs_n=1, o_sclk=CPOL, o_mosi=0, tx_ren=0, rx_wen=0, rx_data=0, o_busy=0, o_overrun=0, and all counters and the shift register to 0.
REQ-032 A reset in the middle of a word SHALL discard that word with no rx_wen pulse; after release, operation SHALL resume from IDLE.

Verification
REQ-033 Single word test: tx_data=0xA5, i_miso looped to o_mosi, defaults -> one tx_ren pulse; o_cs_n low for 34 cycles; 8 o_sclk rising edges; one rx_wen pulse with rx_data=0xA5.
REQ-034 Back-to-back test: FIFO holds 0x3C and 0xF0 with i_en=1 -> two tx_ren pulses; o_cs_n stays low between words; rx_data sequence 0x3C then 0xF0.
REQ-035 Empty FIFO test: tx_empty=1 and i_en=1 for 50 cycles -> tx_ren=0, o_cs_n=1, o_busy=0 throughout.
REQ-036 RX overrun test: rx_full=1 during DONE -> no rx_wen pulse; o_overrun=1 and it remains 1 after a later clean word.
REQ-037 Mid-word reset test: i_rst pulsed during bit 4 -> all outputs at reset values within the same cycle, with no rx_wen pulse.
REQ-038 Enable-drop test: i_en falls during bit 2 with the FIFO non-empty -> the current word completes with rx_wen, then IDLE with o_cs_n=1 and no further tx_ren.
